// File: rtl/ctrl_ramdrv_addrgen_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_ramdrv_addrgen_pkg
//   Shared definitions for the RAM-driver tap address generator:
//   default widths, the sweep FSM state type and a width helper.
// ----------------------------------------------------------------------------
package ctrl_ramdrv_addrgen_pkg;

    localparam int OFFSET_WIDTH_DEF = 10;
    localparam int INDEX_WIDTH_DEF  = 4;
    localparam int TAPS_WIDTH_DEF   = 10;

    // IDLE must stay at zero so a cleared state register means "idle".
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GEN  = 2'd2,
        ST_INCR = 2'd3
    } state_t;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_ramdrv_ptr.sv
// ----------------------------------------------------------------------------
// ctrl_ramdrv_ptr
//   Ring pointer that walks backwards through offsets 0..length.
//   Ports:
//     clk, clr_n   clock, asynchronous active-low clear
//     load         load ptr from load_val (takes priority over dec)
//     load_val     value loaded on load
//     dec          step ptr down by one, wrapping 0 -> length
//     length       last valid ring offset
//     ptr          current ring offset
// ----------------------------------------------------------------------------
module ctrl_ramdrv_ptr #(
    parameter int OFFSET_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    load,
    input  logic [OFFSET_WIDTH-1:0] load_val,
    input  logic                    dec,
    input  logic [OFFSET_WIDTH-1:0] length,
    output logic [OFFSET_WIDTH-1:0] ptr
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (dec) begin
            ptr <= (ptr == '0) ? length : ptr - OFFSET_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ctrl_ramdrv_addrgen.sv
// ----------------------------------------------------------------------------
// ctrl_ramdrv_addrgen
//   Generates one sweep of RAM tap addresses {channel, offset} for a channel
//   whose samples live in a ring buffer. The sweep reads the channel head
//   from the header store, emits up to length+1 offsets walking backwards
//   from the head with wrap, then strobes a header increment.
//   Ports:
//     clk, clr_n    clock, asynchronous active-low reset
//     start         sweep request, accepted only while idle
//     index         channel number (latched on accepted start)
//     length        last valid ring offset (latched on accepted start)
//     taps          addresses requested (latched, clamped to ring size)
//     head_offset   head from header store, used while hdr_read=1
//     hdr_index     channel presented to header store
//     hdr_read      header read strobe
//     hdr_incr      header increment strobe
//     addr          RAM address {channel, offset}
//     addr_valid    addr is valid
//     addr_ready    consumer accepts addr
//     busy          sweep in progress
//     done          one-cycle completion pulse
// ----------------------------------------------------------------------------
module ctrl_ramdrv_addrgen
    import ctrl_ramdrv_addrgen_pkg::*;
#(
    parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
    parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
    parameter int TAPS_WIDTH   = TAPS_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                clr_n,
    input  logic                                start,
    input  logic [INDEX_WIDTH-1:0]              index,
    input  logic [OFFSET_WIDTH-1:0]             length,
    input  logic [TAPS_WIDTH-1:0]               taps,
    input  logic [OFFSET_WIDTH-1:0]             head_offset,
    output logic [INDEX_WIDTH-1:0]              hdr_index,
    output logic                                hdr_read,
    output logic                                hdr_incr,
    output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] addr,
    output logic                                addr_valid,
    input  logic                                addr_ready,
    output logic                                busy,
    output logic                                done
);

    // Wide enough for both the tap count and length+1 (ring size of an
    // all-ones length) so the clamp never overflows.
    localparam int CNT_W = max_width(TAPS_WIDTH, OFFSET_WIDTH + 1);

    state_t                  state;
    logic [INDEX_WIDTH-1:0]  idx_q;
    logic [OFFSET_WIDTH-1:0] len_q;
    logic [CNT_W-1:0]        remain;
    logic [OFFSET_WIDTH-1:0] ptr;
    logic                    handshake;

    // Number of addresses actually emitted: the ring cannot supply more
    // distinct samples than its size.
    function automatic logic [CNT_W-1:0] clamp_taps(
        input logic [TAPS_WIDTH-1:0]   t,
        input logic [OFFSET_WIDTH-1:0] l
    );
        logic [CNT_W-1:0] ring;
        logic [CNT_W-1:0] tt;
        ring = CNT_W'(l) + CNT_W'(1);
        tt   = CNT_W'(t);
        return (tt < ring) ? tt : ring;
    endfunction

    assign handshake = addr_valid & addr_ready;

    // Pointer loads from the header during the read cycle (hdr_read marks it)
    // and steps back once per accepted address.
    ctrl_ramdrv_ptr #(
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_ptr (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (hdr_read),
        .load_val (head_offset),
        .dec      (handshake),
        .length   (len_q),
        .ptr      (ptr)
    );

    // While idle the header store sees the live index so it can be
    // pre-addressed; once busy it sees the latched channel.
    assign hdr_index = busy ? idx_q : index;

    // addr_valid is only ever set in GEN, and both fields clear on reset,
    // so gating keeps addr at zero whenever nothing is offered.
    assign addr = addr_valid ? {idx_q, ptr} : '0;

    // Sweep FSM; strobes are registered and set on the transition into the
    // state they belong to.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            remain     <= '0;
            busy       <= 1'b0;
            hdr_read   <= 1'b0;
            hdr_incr   <= 1'b0;
            addr_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx_q    <= index;
                        len_q    <= length;
                        remain   <= clamp_taps(taps, length);
                        state    <= ST_READ;
                        busy     <= 1'b1;
                        hdr_read <= 1'b1;
                    end
                end
                ST_READ: begin
                    hdr_read <= 1'b0;
                    if (remain == '0) begin
                        state    <= ST_INCR;
                        hdr_incr <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        state      <= ST_GEN;
                        addr_valid <= 1'b1;
                    end
                end
                ST_GEN: begin
                    if (handshake) begin
                        remain <= remain - CNT_W'(1);
                        if (remain == CNT_W'(1)) begin
                            state      <= ST_INCR;
                            addr_valid <= 1'b0;
                            hdr_incr   <= 1'b1;
                            done       <= 1'b1;
                        end
                    end
                end
                ST_INCR: begin
                    state    <= ST_IDLE;
                    hdr_incr <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    hdr_read   <= 1'b0;
                    hdr_incr   <= 1'b0;
                    addr_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_ramdrv_addrgen.sv
// ----------------------------------------------------------------------------
// tb_ctrl_ramdrv_addrgen
//   Self-checking bench: a sweep task drives transactions and states, for
//   every cycle, what the outputs must be from the sweep rules (head, wrap,
//   clamp, handshake count); a negedge process compares against the DUT and
//   records every accepted address for literal sequence checks.
// ----------------------------------------------------------------------------
module tb_ctrl_ramdrv_addrgen;

    localparam int OW = 10;
    localparam int IW = 4;
    localparam int TW = 10;
    localparam int AW = IW + OW;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          start;
    logic [IW-1:0] index;
    logic [OW-1:0] length;
    logic [TW-1:0] taps;
    logic [OW-1:0] head_offset;
    logic [IW-1:0] hdr_index;
    logic          hdr_read;
    logic          hdr_incr;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          addr_ready;
    logic          busy;
    logic          done;

    ctrl_ramdrv_addrgen #(
        .OFFSET_WIDTH(OW),
        .INDEX_WIDTH (IW),
        .TAPS_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .index      (index),
        .length     (length),
        .taps       (taps),
        .head_offset(head_offset),
        .hdr_index  (hdr_index),
        .hdr_read   (hdr_read),
        .hdr_incr   (hdr_incr),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic          chk_en = 1'b0;
    logic          exp_busy, exp_read, exp_incr, exp_done, exp_valid;
    logic [IW-1:0] exp_hidx;
    logic [AW-1:0] exp_addr;
    int            got_q[$];
    int            lit_q[$];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endfunction

    // Per-cycle comparison against the expectation for the current cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       32'(busy),       32'(exp_busy));
            check("hdr_read",   32'(hdr_read),   32'(exp_read));
            check("hdr_incr",   32'(hdr_incr),   32'(exp_incr));
            check("done",       32'(done),       32'(exp_done));
            check("addr_valid", 32'(addr_valid), 32'(exp_valid));
            check("hdr_index",  32'(hdr_index),  32'(exp_hidx));
            if (exp_valid)
                check("addr", 32'(addr), 32'(exp_addr));
            if (addr_valid && addr_ready)
                got_q.push_back(int'(addr));
        end
    end

    task automatic set_exp(input logic b, input logic r, input logic inc, input logic v, input int hidx);
        exp_busy  = b;
        exp_read  = r;
        exp_incr  = inc;
        exp_done  = inc;
        exp_valid = v;
        exp_hidx  = IW'(hidx);
    endtask

    task automatic check_lits(input string nm);
        check({nm, "_count"}, 32'(got_q.size()), 32'(lit_q.size()));
        for (int k = 0; k < lit_q.size(); k++)
            if (k < got_q.size())
                check({nm, "_addr"}, 32'(got_q[k]), 32'(lit_q[k]));
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = ready pattern 1,0,0,1
    // noisy: assert start with a random index while the sweep is running
    // abort_at: assert clr_n after that many accepted addresses (-1 = never)
    task automatic sweep(input int idx, input int len, input int tp, input int head,
                         input int mode, input bit noisy, input int abort_at);
        int eff, ring, i, k;
        ring = len + 1;
        eff  = (tp < ring) ? tp : ring;
        // idle cycle carrying the request
        @(posedge clk); #1;
        got_q.delete();
        start  = 1'b1;
        index  = IW'(idx);
        length = OW'(len);
        taps   = TW'(tp);
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, idx);
        // header read cycle
        @(posedge clk); #1;
        start       = noisy ? 1'($urandom % 2) : 1'b0;
        index       = noisy ? IW'($urandom) : IW'(idx);
        head_offset = OW'(head);
        set_exp(1'b1, 1'b1, 1'b0, 1'b0, idx);
        i = 0;
        k = 0;
        while (i < eff) begin
            @(posedge clk); #1;
            if (abort_at >= 0 && i == abort_at) begin
                chk_en = 1'b0;
                clr_n  = 1'b0;
                #1;
                check("rst_addr_valid", 32'(addr_valid), 0);
                check("rst_hdr_read",   32'(hdr_read),   0);
                check("rst_hdr_incr",   32'(hdr_incr),   0);
                check("rst_busy",       32'(busy),       0);
                check("rst_done",       32'(done),       0);
                check("rst_addr",       32'(addr),       0);
                check("abort_seen",     32'(got_q.size()), 32'(abort_at));
                repeat (2) begin
                    @(posedge clk); #1;
                    check("rst_hold_incr", 32'(hdr_incr), 0);
                end
                start  = 1'b0;
                index  = IW'(idx);
                clr_n  = 1'b1;
                set_exp(1'b0, 1'b0, 1'b0, 1'b0, idx);
                chk_en = 1'b1;
                return;
            end
            start       = noisy ? 1'($urandom % 2) : 1'b0;
            index       = noisy ? IW'($urandom) : IW'(idx);
            head_offset = OW'($urandom);
            case (mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = (k >= 200) ? 1'b1 : 1'(($urandom % 3) != 0);
                default: addr_ready = ((k % 4) == 0) || ((k % 4) == 3);
            endcase
            set_exp(1'b1, 1'b0, 1'b0, 1'b1, idx);
            exp_addr = AW'(idx * (1 << OW) + ((head - i + ring) % ring));
            if (addr_ready) i++;
            k++;
        end
        // increment/done cycle
        @(posedge clk); #1;
        start = noisy ? 1'($urandom % 2) : 1'b0;
        index = noisy ? IW'($urandom) : IW'(idx);
        set_exp(1'b1, 1'b0, 1'b1, 1'b0, idx);
        // back to idle
        @(posedge clk); #1;
        start = 1'b0;
        index = IW'(idx);
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, idx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n       = 1'b0;
        start       = 1'b0;
        index       = '0;
        length      = '0;
        taps        = '0;
        head_offset = '0;
        addr_ready  = 1'b0;
        exp_addr    = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // reset state, with a request pending that must not be taken
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        index = IW'(9);
        #2;
        check("init_addr_valid", 32'(addr_valid), 0);
        check("init_hdr_read",   32'(hdr_read),   0);
        check("init_hdr_incr",   32'(hdr_incr),   0);
        check("init_busy",       32'(busy),       0);
        check("init_done",       32'(done),       0);
        check("init_addr",       32'(addr),       0);
        check("init_hdr_index",  32'(hdr_index),  9);
        start = 1'b0;
        clr_n = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 9);
        chk_en = 1'b1;

        // channel 3, ring of 8, head 2, four taps
        sweep(3, 7, 4, 2, 0, 1'b0, -1);
        lit_q = {3074, 3073, 3072, 3079};
        check_lits("basic");

        // taps above ring size are clamped to four addresses
        sweep(5, 3, 9, 1, 0, 1'b0, -1);
        lit_q = {5121, 5120, 5123, 5122};
        check_lits("clamp");

        // zero taps: read then increment, nothing emitted
        sweep(7, 5, 0, 3, 0, 1'b0, -1);
        lit_q.delete();
        check_lits("zero_taps");

        // stalls with ready 1,0,0,1 must neither skip nor repeat
        sweep(2, 5, 4, 0, 2, 1'b0, -1);
        lit_q = {2048, 2053, 2052, 2051};
        check_lits("stall");

        // single-entry ring
        sweep(1, 0, 3, 0, 1, 1'b0, -1);
        lit_q = {1024};
        check_lits("ring1");

        // start with another channel while busy is ignored
        sweep(4, 6, 5, 6, 1, 1'b1, -1);
        lit_q = {4102, 4101, 4100, 4099, 4098};
        check_lits("noisy");

        // reset mid-sweep, then a fresh sweep
        sweep(2, 9, 8, 4, 0, 1'b0, 2);
        sweep(6, 4, 3, 1, 0, 1'b0, -1);
        lit_q = {6145, 6144, 6148};
        check_lits("post_reset");

        // randomized sweeps
        for (int n = 0; n < 40; n++) begin
            int r_len;
            r_len = int'($urandom_range(0, 15));
            sweep(int'($urandom_range(0, 15)), r_len, int'($urandom_range(0, 20)),
                  int'($urandom_range(0, r_len)), int'($urandom_range(0, 2)),
                  1'($urandom % 2), -1);
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
